thermal_fb_scheduler: RTL and testbench

Shares one single-port synchronous frame-buffer RAM between the thermal sensor writer and the VGA display read path. Display reads always take priority; the writer fills a back bank during the remaining cycles. A full back bank is swapped to the front at a fixed frame boundary, so the display never shows a torn image. The block sits between vga_gen's pixel counters, the sensor capture logic and the BRAM.

---
 rtl/thermal_fb_scheduler.sv | 136 +++++++++++++
 tb/tb_thermal_fb_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/thermal_fb_scheduler.sv
// Arbitrates a single-port frame-buffer RAM between VGA display reads (priority)
// and a sensor writer filling the back bank; swaps banks at the frame boundary.
module thermal_fb_scheduler #(
    parameter int SRC_W      = 32,
    parameter int SRC_H      = 24,
    parameter int SCALE_LOG2 = 4,
    parameter int WIN_X0     = 64,
    parameter int WIN_Y0     = 48,
    parameter int DISP_H     = 480,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 11
) (
    input  logic              i_clk_pixel,
    input  logic              i_rst_n,
    input  logic [9:0]        i_x,
    input  logic [9:0]        i_y,
    input  logic              i_data_en,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [9:0]        i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [DATA_W-1:0] o_pix_data,
    output logic              o_pix_in_win,
    output logic              o_swap,
    output logic              o_rd_bank,
    output logic              o_dbg_state
);

    localparam int CELLS  = SRC_W * SRC_H;
    localparam int WIN_X1 = WIN_X0 + (SRC_W << SCALE_LOG2);
    localparam int WIN_Y1 = WIN_Y0 + (SRC_H << SCALE_LOG2);
    localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(CELLS);
    localparam logic [ADDR_W-1:0] SRC_W_A = ADDR_W'(SRC_W);

    typedef enum logic {ST_FILL = 1'b0, ST_PENDING = 1'b1} state_t;

    state_t state, state_next;

    logic              in_win;
    logic              boundary;
    logic              wr_in_range;
    logic              wr_last;
    logic              wr_ready;
    logic              wr_fire;
    logic              swap_now;
    logic [9:0]        dx, dy, cell_x, cell_y;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_full_addr;
    logic              win_d1, win_d2;

    assign in_win = i_data_en
                 && (i_x >= 10'(WIN_X0)) && (i_x < 10'(WIN_X1))
                 && (i_y >= 10'(WIN_Y0)) && (i_y < 10'(WIN_Y1));
    assign boundary = (i_x == 10'd0) && (i_y == 10'(DISP_H));

    assign dx      = i_x - 10'(WIN_X0);
    assign dy      = i_y - 10'(WIN_Y0);
    assign cell_x  = dx >> SCALE_LOG2;
    assign cell_y  = dy >> SCALE_LOG2;
    assign rd_addr = (o_rd_bank ? CELLS_A : '0) + ADDR_W'(cell_y) * SRC_W_A + ADDR_W'(cell_x);

    // The writer always targets the bank not being displayed.
    assign wr_full_addr = (o_rd_bank ? '0 : CELLS_A) + ADDR_W'(i_wr_addr);
    assign wr_in_range  = i_wr_addr < 10'(CELLS);
    assign wr_last      = i_wr_addr == 10'(CELLS - 1);
    assign wr_fire      = i_wr_valid && wr_ready;

    // Handshake: a cell transfers on any cycle where i_wr_valid && o_wr_ready;
    // ready never depends on valid. Out-of-range cells are consumed but not stored.
    assign o_wr_ready  = wr_ready && i_rst_n;
    assign o_dbg_state = state;

    always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_FILL;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        swap_now   = 1'b0;
        case (state)
            ST_FILL: begin
                wr_ready = !in_win;
                if (i_wr_valid && !in_win && wr_last) state_next = ST_PENDING;
            end
            ST_PENDING: begin
                if (boundary) begin
                    swap_now   = 1'b1;
                    state_next = ST_FILL;
                end
            end
            default: state_next = ST_FILL;
        endcase
    end

    always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ram_en     <= 1'b0;
            o_ram_we     <= 1'b0;
            o_ram_addr   <= '0;
            o_ram_wdata  <= '0;
            win_d1       <= 1'b0;
            win_d2       <= 1'b0;
            o_pix_in_win <= 1'b0;
            o_pix_data   <= '0;
            o_swap       <= 1'b0;
            o_rd_bank    <= 1'b0;
        end else begin
            o_ram_en <= 1'b0;
            o_ram_we <= 1'b0;
            if (in_win) begin
                o_ram_en   <= 1'b1;
                o_ram_addr <= rd_addr;
            end else if (wr_fire && wr_in_range) begin
                o_ram_en    <= 1'b1;
                o_ram_we    <= 1'b1;
                o_ram_addr  <= wr_full_addr;
                o_ram_wdata <= i_wr_data;
            end
            // Window flag tracks the read through the RAM's one-cycle latency.
            win_d1       <= in_win;
            win_d2       <= win_d1;
            o_pix_in_win <= win_d2;
            o_pix_data   <= win_d2 ? i_ram_rdata : '0;
            o_swap       <= swap_now;
            if (swap_now) o_rd_bank <= ~o_rd_bank;
        end
    end

endmodule

// File: tb/tb_thermal_fb_scheduler.sv
// Randomized and directed bench for thermal_fb_scheduler against a cell-level
// frame-buffer model with an attached behavioural RAM.
module tb_thermal_fb_scheduler;

    localparam int CELLS  = 768;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [9:0]        x = '0, y = '0;
    logic              de = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [9:0]        wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic [DATA_W-1:0] pix_data;
    logic              pix_in_win, swap, rd_bank, dbg_state;

    logic [DATA_W-1:0] mem [0:2047];

    int n_checks = 0;
    int n_fail   = 0;

    int img [0:2*CELLS-1];
    int m_bank = 0;
    int m_full = 0;
    logic [DATA_W:0] exp_q[$];

    thermal_fb_scheduler dut (
        .i_clk_pixel(clk), .i_rst_n(rst_n), .i_x(x), .i_y(y), .i_data_en(de),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata), .o_pix_data(pix_data), .o_pix_in_win(pix_in_win),
        .o_swap(swap), .o_rd_bank(rd_bank), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One pixel-clock cycle: drive inputs at the falling edge, predict, check after the rising edge.
    task automatic cycle(input int cx, input int cy, input bit cde, input bit valid,
                         input int addr, input int data, output bit accepted);
        bit win, rdy, bnd, wr, sw;
        int ra, wa, pv;
        x = 10'(cx); y = 10'(cy); de = cde;
        wr_valid = valid; wr_addr = 10'(addr); wr_data = 8'(data);
        #1;
        win = cde && cx >= 64 && cx < 64 + 32 * 16 && cy >= 48 && cy < 48 + 24 * 16;
        rdy = (m_full == 0) && !win;
        bnd = (cx == 0) && (cy == 480);
        check("wr_ready", wr_ready, rdy);
        accepted = valid && rdy;
        ra = m_bank * CELLS + ((cy - 48) / 16) * 32 + (cx - 64) / 16;
        wa = (1 - m_bank) * CELLS + addr;
        wr = accepted && addr < CELLS;
        pv = win ? img[ra] : 0;
        exp_q.push_back({win, 8'(pv)});
        sw = (m_full == 1) && bnd;
        if (wr) img[wa] = data & 8'hFF;
        if (accepted && addr == CELLS - 1) m_full = 1;
        if (sw) begin
            m_full = 0;
            m_bank = 1 - m_bank;
        end
        @(posedge clk);
        @(negedge clk);
        check("ram_en", ram_en, win || wr);
        check("ram_we", ram_we, !win && wr);
        if (win) check("rd_addr", ram_addr, ra);
        if (wr) begin
            check("wr_addr", ram_addr, wa);
            check("wr_data", ram_wdata, data & 8'hFF);
        end
        check("swap", swap, sw);
        check("rd_bank", rd_bank, m_bank);
        check("state", dbg_state, m_full);
        if (exp_q.size() >= 3) begin
            logic [DATA_W:0] e;
            e = exp_q.pop_front();
            check("pix_in_win", pix_in_win, e[DATA_W]);
            check("pix_data", pix_data, e[DATA_W-1:0]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_en"}, ram_en, 0);
        check({tag, "_ram_we"}, ram_we, 0);
        check({tag, "_ram_addr"}, ram_addr, 0);
        check({tag, "_ram_wdata"}, ram_wdata, 0);
        check({tag, "_pix"}, pix_data, 0);
        check({tag, "_in_win"}, pix_in_win, 0);
        check({tag, "_swap"}, swap, 0);
        check({tag, "_rd_bank"}, rd_bank, 0);
        check({tag, "_wr_ready"}, wr_ready, 0);
    endtask

    // Asynchronous assert mid-cycle, synchronous release on a falling edge.
    task automatic do_reset(input int cx, input int cy, input bit cde);
        x = 10'(cx); y = 10'(cy); de = cde; wr_valid = 1'b1; wr_addr = 10'd767;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs("rst_hold");
        end
        rst_n = 1'b1;
        m_bank = 0;
        m_full = 0;
        exp_q.delete();
    endtask

    task automatic random_run(input int n, inout int wc);
        bit acc;
        int cx, cy, a, d;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                cx = $urandom_range(576, 799);
                cy = $urandom_range(0, 524);
            end else begin
                cx = $urandom_range(0, 799);
                cy = $urandom_range(0, 524);
            end
            a = ($urandom_range(0, 19) == 0) ? $urandom_range(768, 1023) : wc;
            d = $urandom_range(0, 255);
            cycle(cx, cy, cx < 640 && cy < 480, $urandom_range(0, 3) != 0, a, d, acc);
            if (acc && a == wc) wc = (wc + 1) % CELLS;
        end
    endtask

    initial begin
        bit acc;
        int wc;
        for (int i = 0; i < 2048; i++) mem[i] = 8'((i < CELLS) ? i : i * 7 + 3);
        for (int i = 0; i < 2 * CELLS; i++) img[i] = (i < CELLS) ? (i & 255) : ((i * 7 + 3) & 255);

        // Power-on reset held mid-frame with a writer presenting a cell.
        @(negedge clk);
        do_reset(700, 60, 1'b0);

        // Display read wins over a pending write; blanking lets the write through.
        cycle(100, 60, 1, 1, 5, 8'h11, acc);
        check("prio_no_write", ram_we, 0);
        cycle(700, 60, 0, 1, 5, 8'h22, acc);
        check("blank_write_addr", ram_addr, 768 + 5);

        // Cell (5,2) of bank 0 holds 69; three cycles later the pixel shows it.
        cycle(64 + 16 * 5, 48 + 16 * 2, 1, 0, 0, 0, acc);
        check("addr_69", ram_addr, 69);
        cycle(10, 60, 1, 0, 0, 0, acc);
        cycle(700, 60, 0, 0, 0, 0, acc);
        check("pix_69", pix_data, 69);
        check("pix_69_win", pix_in_win, 1);
        for (int i = 0; i < 3; i++) cycle(700, 61, 0, 0, 0, 0, acc);

        // Fill back bank with 0xA5, then swap at the boundary.
        for (int i = 0; i < CELLS; i++) cycle(700, 100, 0, 1, i, 8'hA5, acc);
        check("pending", dbg_state, 1);
        cycle(700, 101, 0, 1, 3, 8'h01, acc);
        cycle(0, 480, 0, 0, 0, 0, acc);
        check("swap_pulse", swap, 1);
        check("swap_bank", rd_bank, 1);
        cycle(64, 48, 1, 0, 0, 0, acc);
        cycle(300, 200, 1, 0, 0, 0, acc);
        cycle(575, 431, 1, 0, 0, 0, acc);
        cycle(700, 0, 0, 0, 0, 0, acc);
        check("pix_a5", pix_data, 8'hA5);
        cycle(700, 0, 0, 0, 0, 0, acc);
        cycle(700, 0, 0, 0, 0, 0, acc);

        // Last cell lands on the boundary cycle: swap waits a frame.
        for (int i = 0; i < CELLS - 1; i++) cycle(700, 200, 0, 1, i, $urandom_range(0, 255), acc);
        cycle(0, 480, 0, 1, CELLS - 1, 8'h5A, acc);
        check("corner_no_swap", swap, 0);
        check("corner_pending", dbg_state, 1);
        for (int i = 0; i < 10; i++) cycle(64 + 16 * i, 100, 1, 1, 0, 0, acc);
        cycle(0, 480, 0, 0, 0, 0, acc);
        check("corner_swap", swap, 1);
        check("corner_bank", rd_bank, 0);
        cycle(700, 300, 0, 1, 800, 8'h77, acc);
        check("oob_dropped", ram_en, 0);
        check("oob_state", dbg_state, 0);
        for (int i = 0; i < 4; i++) cycle(64 + 37 * i, 48 + 29 * i, 1, 0, 0, 0, acc);

        // Soak: three frames of random traffic, each closed by a boundary.
        wc = 0;
        for (int f = 0; f < 3; f++) begin
            random_run(2500, wc);
            cycle(0, 480, 0, 0, 0, 0, acc);
        end

        // Reset with a partly filled back bank discards it.
        @(negedge clk);
        do_reset(200, 100, 1'b1);
        wc = 0;
        random_run(400, wc);
        cycle(0, 480, 0, 0, 0, 0, acc);
        for (int i = 0; i < 3; i++) cycle(700, 10, 0, 0, 0, 0, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
